// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared data memory types and requester indexing
package types_pkg;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int MEM_SIZE = 1024;
  localparam int NUM_REQ  = 2;

  typedef logic [ADDR_W-1:0] address_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic              req_id_t;
endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// rtl/data_mem_arbiter_rr_arb2.sv - two-way round-robin grant with priority register
module rr_arb2
  import types_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output req_id_t            gnt_id_o
);
  req_id_t prio_q, prio_d;

  always_comb begin
    gnt_o = '0;
    if (!rst_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    gnt_id_o = gnt_o[1];
    // The loser of any grant, contended or not, gets first claim next time.
    prio_d = prio_q;
    if (|gnt_o) prio_d = ~gnt_o[1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares single-port data_mem between two cores
module data_mem_arbiter
  import types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic     [NUM_REQ-1:0]   req_i,
  input  logic     [NUM_REQ-1:0]   we_i,
  input  address_t [NUM_REQ-1:0]   addr_i,
  input  word_t    [NUM_REQ-1:0]   wdata_i,
  output logic     [NUM_REQ-1:0]   gnt_o,
  output logic     [NUM_REQ-1:0]   rvalid_o,
  output word_t    [NUM_REQ-1:0]   rdata_o,
  output logic     [NUM_REQ-1:0]   addr_err_o,
  output logic                     mem_we_o,
  output address_t                 mem_addr_o,
  output word_t                    mem_wdata_o,
  input  word_t                    mem_rdata_i,
  output logic     [CNT_W-1:0]     conflict_cnt_o
);
  req_id_t            sel;
  logic               in_range;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .gnt_id_o (sel)
  );

  // With no grant sel is 0, so the memory bus idles on requester 0's fields.
  always_comb begin
    mem_addr_o  = addr_i[sel];
    mem_wdata_o = wdata_i[sel];
    in_range    = (mem_addr_o < address_t'(MEM_SIZE));
    mem_we_o    = (|gnt_o) & we_i[sel] & in_range;
    rvalid_d    = gnt_o & ~we_i;
    err_d       = gnt_o & {NUM_REQ{~in_range}};
    cnt_d       = cnt_q;
    if ((&req_i) && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  // Masking with rst_i drops a load granted in the cycle just before reset.
  always_comb begin
    rvalid_o   = rst_i ? '0 : rvalid_q;
    addr_err_o = rst_i ? '0 : err_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      rdata_o[i] = (rvalid_o[i] && !err_q[i]) ? mem_rdata_i : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= '0;
      err_q    <= '0;
      cnt_q    <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign conflict_cnt_o = cnt_q;
endmodule
